vproc_sld_wb: RTL and testbench

VPROC_SLD_WB -- requirements
Module: vproc_sld_wb

---
 rtl/vproc_sld_wb_if.sv | 59 +++++
 rtl/vproc_sld_wb.sv | 136 +++++++++++++
 tb/tb_vproc_sld_wb.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/vproc_sld_wb_if.sv
// Bus bundles for the slide writeback stage: the incoming result-chunk stream
// and the outgoing vector register write port.
interface vproc_sld_pipe_if #(
    parameter int unsigned SLD_OP_W = 64
);
    logic                  pipe_in_valid_i;
    logic                  pipe_in_ready_o;
    logic [4:0]            pipe_in_vd_i;
    logic                  pipe_in_last_i;
    logic [SLD_OP_W-1:0]   pipe_in_res_i;
    logic [SLD_OP_W/8-1:0] pipe_in_mask_i;

    modport master (
        output pipe_in_valid_i,
        output pipe_in_vd_i,
        output pipe_in_last_i,
        output pipe_in_res_i,
        output pipe_in_mask_i,
        input  pipe_in_ready_o
    );

    modport slave (
        input  pipe_in_valid_i,
        input  pipe_in_vd_i,
        input  pipe_in_last_i,
        input  pipe_in_res_i,
        input  pipe_in_mask_i,
        output pipe_in_ready_o
    );
endinterface

interface vproc_sld_wr_if #(
    parameter int unsigned VREG_W = 128
);
    logic                vreg_wr_valid_o;
    logic                vreg_wr_ready_i;
    logic [4:0]          vreg_wr_addr_o;
    logic [VREG_W-1:0]   vreg_wr_data_o;
    logic [VREG_W/8-1:0] vreg_wr_be_o;
    logic                vreg_wr_last_o;

    modport master (
        output vreg_wr_valid_o,
        input  vreg_wr_ready_i,
        output vreg_wr_addr_o,
        output vreg_wr_data_o,
        output vreg_wr_be_o,
        output vreg_wr_last_o
    );

    modport slave (
        input  vreg_wr_valid_o,
        output vreg_wr_ready_i,
        input  vreg_wr_addr_o,
        input  vreg_wr_data_o,
        input  vreg_wr_be_o,
        input  vreg_wr_last_o
    );
endinterface

// File: rtl/vproc_sld_wb.sv
// Slide-unit writeback: gathers SLD_OP_W result chunks into one VREG_W-wide
// register write, flushing when the buffer is full or the instruction ends.
module vproc_sld_wb #(
    parameter int unsigned VREG_W         = 128,
    parameter int unsigned SLD_OP_W       = 64,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic           clk_i,
    input  logic           async_rst_ni,
    vproc_sld_pipe_if.slave pipe_if,
    vproc_sld_wr_if.master  wr_if
);
    localparam int unsigned CNT    = VREG_W / SLD_OP_W;
    localparam int unsigned IDX_W  = $clog2(CNT);
    localparam int unsigned OP_B   = SLD_OP_W / 8;
    localparam int unsigned VREG_B = VREG_W / 8;

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_next;
    logic [4:0]        r_addr;
    logic              r_last;

    logic              w_accept;
    logic              w_wr_hs;
    logic              w_close;
    logic [VREG_W-1:0] w_data;
    logic [VREG_B-1:0] w_be;

    assign w_accept = pipe_if.pipe_in_valid_i & (r_state == FILL);
    assign w_wr_hs  = wr_if.vreg_wr_ready_i & (r_state == FLUSH);
    // A chunk closes the buffer when it fills the top slot or ends the instruction.
    assign w_close  = w_accept & (pipe_if.pipe_in_last_i | (r_idx == IDX_W'(CNT - 1)));

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            FILL: begin
                if (w_close) begin
                    w_state_next = FLUSH;
                    w_idx_next   = '0;
                end else if (w_accept) begin
                    w_idx_next   = r_idx + IDX_W'(1);
                end
            end
            FLUSH: begin
                if (w_wr_hs) begin
                    w_state_next = FILL;
                    w_idx_next   = '0;
                end
            end
            default: begin
                w_state_next = FILL;
                w_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_state <= FILL;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_addr <= '0;
            r_last <= 1'b0;
        end else begin
            if (w_accept && (r_idx == '0)) begin
                r_addr <= pipe_if.pipe_in_vd_i;
            end
            if (w_close) begin
                r_last <= pipe_if.pipe_in_last_i;
            end else if (w_wr_hs) begin
                r_last <= 1'b0;
            end
        end
    end

    // One buffer slot per chunk position; data needs no reset, enables do.
    generate
        for (genvar gi = 0; gi < CNT; gi++) begin : g_slot
            logic                w_slot_wr;
            logic [SLD_OP_W-1:0] r_data_slot;
            logic [OP_B-1:0]     r_be_slot;

            assign w_slot_wr = w_accept & (r_idx == IDX_W'(gi));

            always_ff @(posedge clk_i) begin
                if (w_slot_wr) begin
                    r_data_slot <= pipe_if.pipe_in_res_i;
                end
            end

            always_ff @(posedge clk_i or negedge async_rst_ni) begin
                if (!async_rst_ni) begin
                    r_be_slot <= '0;
                end else if (w_slot_wr) begin
                    r_be_slot <= pipe_if.pipe_in_mask_i;
                end else if (w_wr_hs) begin
                    r_be_slot <= '0;
                end
            end

            assign w_data[gi*SLD_OP_W +: SLD_OP_W] = r_data_slot;
            assign w_be[gi*OP_B +: OP_B]           = r_be_slot;
        end
    endgenerate

    // Disabled bytes are forced to zero on the way out rather than cleared in the buffer.
    generate
        for (genvar gi = 0; gi < VREG_B; gi++) begin : g_out_byte
            assign wr_if.vreg_wr_data_o[gi*8 +: 8] =
                (DONT_CARE_ZERO && !w_be[gi]) ? 8'h00 : w_data[gi*8 +: 8];
        end
    endgenerate

    assign pipe_if.pipe_in_ready_o = (r_state == FILL);
    assign wr_if.vreg_wr_valid_o   = (r_state == FLUSH);
    assign wr_if.vreg_wr_addr_o    = r_addr;
    assign wr_if.vreg_wr_be_o      = w_be;
    assign wr_if.vreg_wr_last_o    = r_last;

endmodule

// File: tb/tb_vproc_sld_wb.sv
// Directed bench for vproc_sld_wb: a byte-level model of the register being
// assembled is checked every cycle, and each write is pinned to a literal.
module tb_vproc_sld_wb;
    localparam int VW   = 128;
    localparam int OW   = 64;
    localparam int CNT  = VW / OW;
    localparam int NB   = VW / 8;
    localparam int OB   = OW / 8;
    localparam int NLIT = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vproc_sld_pipe_if #(.SLD_OP_W(OW)) pipe_bus ();
    vproc_sld_wr_if   #(.VREG_W(VW))   wr_bus ();

    vproc_sld_wb #(
        .VREG_W         (VW),
        .SLD_OP_W       (OW),
        .DONT_CARE_ZERO (1'b1)
    ) dut (
        .clk_i        (clk),
        .async_rst_ni (rst_n),
        .pipe_if      (pipe_bus),
        .wr_if        (wr_bus)
    );

    // Model: which bytes of the destination register hold what, and whether a write is owed.
    logic          m_pending;
    int            m_cnt;
    logic [4:0]    m_addr;
    logic          m_last;
    logic [NB-1:0] m_be;
    logic [7:0]    m_bytes [NB];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending <= 1'b0;
            m_cnt     <= 0;
            m_addr    <= '0;
            m_last    <= 1'b0;
            m_be      <= '0;
        end else if (!m_pending) begin
            if (pipe_bus.pipe_in_valid_i) begin
                if (m_cnt == 0) m_addr <= pipe_bus.pipe_in_vd_i;
                for (int b = 0; b < OB; b++) begin
                    m_be[m_cnt*OB + b]    <= pipe_bus.pipe_in_mask_i[b];
                    m_bytes[m_cnt*OB + b] <= pipe_bus.pipe_in_res_i[b*8 +: 8];
                end
                if (pipe_bus.pipe_in_last_i || m_cnt == CNT - 1) begin
                    m_pending <= 1'b1;
                    m_last    <= pipe_bus.pipe_in_last_i;
                    m_cnt     <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end else if (wr_bus.vreg_wr_ready_i) begin
            m_pending <= 1'b0;
            m_last    <= 1'b0;
            m_be      <= '0;
        end
    end

    function automatic logic [VW-1:0] model_data();
        logic [VW-1:0] d;
        d = '0;
        for (int b = 0; b < NB; b++) begin
            if (m_be[b]) d[b*8 +: 8] = m_bytes[b];
        end
        return d;
    endfunction

    // Hand-computed writes, in the order the stimulus produces them.
    logic [4:0]    lit_addr [NLIT] = '{5'd3, 5'd5, 5'd10, 5'd12, 5'd7, 5'd1, 5'd6};
    logic [VW-1:0] lit_data [NLIT] = '{
        128'h2222222222222222_1111111111111111,
        128'h0000000000000000_00000000ABABABAB,
        128'hB1B1B1B100000000_A0A0A0A0A0A0A0A0,
        128'h0000D3D3D3D30000_C2C2C2C2C2C2C2C2,
        128'h0000000000000000_0123456789ABCDEF,
        128'h0000000000000000_5555555555555555,
        128'h0000000000000000_8888888888888888
    };
    logic [NB-1:0] lit_be   [NLIT] = '{16'hFFFF, 16'h000F, 16'hF0FF, 16'h3CFF, 16'h00FF, 16'h00FF, 16'h00FF};
    logic          lit_last [NLIT] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    int   total   = 0;
    int   bad     = 0;
    int   lit_idx = 0;
    logic done    = 1'b0;
    logic to_flag = 1'b0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", wr_bus.vreg_wr_valid_o, 0);
            chk("rst_ready", pipe_bus.pipe_in_ready_o, 1);
            chk("rst_addr", wr_bus.vreg_wr_addr_o, 0);
            chk("rst_last", wr_bus.vreg_wr_last_o, 0);
            chk("rst_be", wr_bus.vreg_wr_be_o, 0);
        end else begin
            chk("ready", pipe_bus.pipe_in_ready_o, !m_pending);
            chk("valid", wr_bus.vreg_wr_valid_o, m_pending);
            if (m_pending) begin
                chk("addr", wr_bus.vreg_wr_addr_o, m_addr);
                chk("data", wr_bus.vreg_wr_data_o, model_data());
                chk("be", wr_bus.vreg_wr_be_o, m_be);
                chk("last", wr_bus.vreg_wr_last_o, m_last);
                if (wr_bus.vreg_wr_ready_i) begin
                    if (lit_idx < NLIT) begin
                        chk("lit_addr", wr_bus.vreg_wr_addr_o, lit_addr[lit_idx]);
                        chk("lit_data", wr_bus.vreg_wr_data_o, lit_data[lit_idx]);
                        chk("lit_be", wr_bus.vreg_wr_be_o, lit_be[lit_idx]);
                        chk("lit_last", wr_bus.vreg_wr_last_o, lit_last[lit_idx]);
                    end
                    $display("write %0d: addr=%0d be=%h last=%0b data=%h", lit_idx,
                             wr_bus.vreg_wr_addr_o, wr_bus.vreg_wr_be_o,
                             wr_bus.vreg_wr_last_o, wr_bus.vreg_wr_data_o);
                    lit_idx++;
                end
            end
        end
        if (done) begin
            chk("write_count", lit_idx, NLIT);
            chk("timeout", to_flag, 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [4:0] vd, input logic last,
                        input logic [OW-1:0] res, input logic [OB-1:0] mask);
        int   n;
        logic acc;
        pipe_bus.pipe_in_valid_i = 1'b1;
        pipe_bus.pipe_in_vd_i    = vd;
        pipe_bus.pipe_in_last_i  = last;
        pipe_bus.pipe_in_res_i   = res;
        pipe_bus.pipe_in_mask_i  = mask;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 40) begin
            @(posedge clk);
            acc = !m_pending;
            #1;
            n++;
        end
        if (!acc) to_flag = 1'b1;
        pipe_bus.pipe_in_valid_i = 1'b0;
    endtask

    initial begin
        pipe_bus.pipe_in_valid_i = 1'b0;
        pipe_bus.pipe_in_vd_i    = '0;
        pipe_bus.pipe_in_last_i  = 1'b0;
        pipe_bus.pipe_in_res_i   = '0;
        pipe_bus.pipe_in_mask_i  = '0;
        wr_bus.vreg_wr_ready_i   = 1'b1;
        idle(3);
        rst_n = 1'b1;

        // Two full chunks, last on the second.
        send(5'd3, 1'b0, 64'h1111111111111111, 8'hFF);
        send(5'd0, 1'b1, 64'h2222222222222222, 8'hFF);

        // Partial single chunk closed by last.
        send(5'd5, 1'b1, 64'hABABABABABABABAB, 8'h0F);

        // Back-to-back stream of four chunks.
        send(5'd10, 1'b0, 64'hA0A0A0A0A0A0A0A0, 8'hFF);
        send(5'd11, 1'b0, 64'hB1B1B1B1B1B1B1B1, 8'hF0);
        send(5'd12, 1'b0, 64'hC2C2C2C2C2C2C2C2, 8'hFF);
        send(5'd13, 1'b1, 64'hD3D3D3D3D3D3D3D3, 8'h3C);
        idle(2);

        // Stalled flush with a chunk waiting; vd on chunk 1 is ignored; empty mask still flushes.
        wr_bus.vreg_wr_ready_i = 1'b0;
        send(5'd7, 1'b0, 64'h0123456789ABCDEF, 8'hFF);
        send(5'd9, 1'b0, 64'hFEDCBA9876543210, 8'h00);
        pipe_bus.pipe_in_valid_i = 1'b1;
        pipe_bus.pipe_in_vd_i    = 5'd1;
        pipe_bus.pipe_in_last_i  = 1'b1;
        pipe_bus.pipe_in_res_i   = 64'h5555555555555555;
        pipe_bus.pipe_in_mask_i  = 8'hFF;
        idle(5);
        wr_bus.vreg_wr_ready_i = 1'b1;
        send(5'd1, 1'b1, 64'h5555555555555555, 8'hFF);
        idle(2);

        // Reset during a pending flush drops the write.
        wr_bus.vreg_wr_ready_i = 1'b0;
        send(5'd4, 1'b1, 64'h7777777777777777, 8'hFF);
        idle(2);
        rst_n = 1'b0;
        wr_bus.vreg_wr_ready_i = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send(5'd6, 1'b1, 64'h8888888888888888, 8'hFF);
        idle(3);
        done = 1'b1;
    end
endmodule
